// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: shift-based leak, saturating integration,
// threshold spike with selectable post-spike reset and refractory hold-off.
module lif_neuron_core #(
    parameter int WIDTH    = 8,
    parameter int SHIFT_W  = 3,
    parameter int REFRAC_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    current,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [SHIFT_W-1:0]  leak_shift,
    input  logic [REFRAC_W-1:0] refrac_cycles,
    input  logic                reset_mode,
    output logic [WIDTH-1:0]    state,
    output logic                spike,
    output logic                refractory,
    output logic                out_valid
);

    logic [WIDTH-1:0]    state_q, state_d;
    logic                spike_q, spike_d;
    logic                refractory_q, refractory_d;
    logic                out_valid_q, out_valid_d;
    logic [REFRAC_W-1:0] counter_q, counter_d;

    logic [WIDTH-1:0] decayed;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;
    logic             fire;

    // Shifting by >= WIDTH naturally yields zero.
    assign decayed = state_q >> leak_shift;
    assign sum     = {1'b0, decayed} + {1'b0, current};
    assign sat     = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    assign fire    = (threshold != '0) && (sat >= threshold);

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        spike_d      = 1'b0;
        out_valid_d  = in_valid;
        if (in_valid) begin
            if (counter_q != '0) begin
                state_d   = decayed;
                counter_d = counter_q - REFRAC_W'(1);
            end else if (fire) begin
                spike_d   = 1'b1;
                state_d   = reset_mode ? (sat - threshold) : '0;
                counter_d = refrac_cycles;
            end else begin
                state_d = sat;
            end
        end
        refractory_d = (counter_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= '0;
            spike_q      <= 1'b0;
            refractory_q <= 1'b0;
            out_valid_q  <= 1'b0;
            counter_q    <= '0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike_d;
            refractory_q <= refractory_d;
            out_valid_q  <= out_valid_d;
            counter_q    <= counter_d;
        end
    end

    assign state      = state_q;
    assign spike      = spike_q;
    assign refractory = refractory_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core with hand-computed expected values.
module tb_lif_neuron_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] current = '0;
    logic [7:0] threshold = '0;
    logic [2:0] leak_shift = '0;
    logic [3:0] refrac_cycles = '0;
    logic       reset_mode = 1'b0;
    logic [7:0] state;
    logic       spike;
    logic       refractory;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    lif_neuron_core #(.WIDTH(8), .SHIFT_W(3), .REFRAC_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .current       (current),
        .threshold     (threshold),
        .leak_shift    (leak_shift),
        .refrac_cycles (refrac_cycles),
        .reset_mode    (reset_mode),
        .state         (state),
        .spike         (spike),
        .refractory    (refractory),
        .out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input int cur,
                        input int es, input logic esp, input logic er);
        @(negedge clk);
        in_valid = v;
        current  = 8'(cur);
        @(posedge clk);
        #1;
        chk({tag, ".state"}, int'(state), es);
        chk({tag, ".spike"}, int'(spike), int'(esp));
        chk({tag, ".refr"}, int'(refractory), int'(er));
        chk({tag, ".ovld"}, int'(out_valid), int'(v));
    endtask

    task automatic do_reset(input string tag, input logic v, input int cur);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = v;
        current  = 8'(cur);
        @(posedge clk);
        #1;
        chk({tag, ".state"}, int'(state), 0);
        chk({tag, ".spike"}, int'(spike), 0);
        chk({tag, ".refr"}, int'(refractory), 0);
        chk({tag, ".ovld"}, int'(out_valid), 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int leak_exp[6];
        leak_exp = '{10, 15, 17, 18, 19, 19};

        do_reset("rst0", 1'b0, 0);

        // Leak-only integration, with a gap after step 3
        threshold = 8'd0; leak_shift = 3'd1; reset_mode = 1'b0;
        refrac_cycles = 4'd0;
        for (int i = 0; i < 6; i++) begin
            step($sformatf("leak%0d", i), 1'b1, 10, leak_exp[i], 1'b0, 1'b0);
            if (i == 2) begin
                step("gap0", 1'b0, 99, 17, 1'b0, 1'b0);
                step("gap1", 1'b0, 99, 17, 1'b0, 1'b0);
            end
        end

        // Reset-to-zero firing
        do_reset("rst1", 1'b0, 0);
        threshold = 8'd40;
        step("rz1", 1'b1, 30, 30, 1'b0, 1'b0);
        step("rz2", 1'b1, 30, 0, 1'b1, 1'b0);
        step("rz3", 1'b1, 30, 30, 1'b0, 1'b0);
        step("rz4", 1'b1, 30, 0, 1'b1, 1'b0);

        // Subtract mode
        do_reset("rst2", 1'b0, 0);
        reset_mode = 1'b1;
        step("sub1", 1'b1, 30, 30, 1'b0, 1'b0);
        step("sub2", 1'b1, 30, 5, 1'b1, 1'b0);
        step("sub3", 1'b1, 30, 32, 1'b0, 1'b0);
        step("sub4", 1'b1, 30, 6, 1'b1, 1'b0);

        // Refractory period
        do_reset("rst3", 1'b0, 0);
        reset_mode = 1'b0; refrac_cycles = 4'd2;
        step("ref1", 1'b1, 50, 0, 1'b1, 1'b1);
        step("ref2", 1'b1, 50, 0, 1'b0, 1'b1);
        step("ref3", 1'b1, 50, 0, 1'b0, 1'b0);
        step("ref4", 1'b1, 50, 0, 1'b1, 1'b1);
        step("ref5", 1'b1, 50, 0, 1'b0, 1'b1);
        step("ref6", 1'b1, 50, 0, 1'b0, 1'b0);
        step("ref7", 1'b1, 50, 0, 1'b1, 1'b1);
        step("refgap", 1'b0, 50, 0, 1'b0, 1'b1);

        // Reset mid-refractory (counter=2) with in_valid high: reset wins
        do_reset("rst4", 1'b1, 50);
        step("post", 1'b1, 20, 20, 1'b0, 1'b0);

        // Saturation, then fire at threshold 255
        do_reset("rst5", 1'b0, 0);
        leak_shift = 3'd0; threshold = 8'd0; refrac_cycles = 4'd0;
        step("sat1", 1'b1, 200, 200, 1'b0, 1'b0);
        step("sat2", 1'b1, 200, 255, 1'b0, 1'b0);
        step("sat3", 1'b1, 200, 255, 1'b0, 1'b0);
        threshold = 8'd255;
        step("sat4", 1'b1, 200, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_neuron_core.md
Name: lif_neuron_core

Overview:
- Parametrised leaky integrate-and-fire neuron. It generalises the fixed beta=0.5 leaky integrator.
- Adds the following:
  - run-time leak shift (beta = 2^-k)
  - firing threshold with a registered spike output
  - selectable post-spike reset mode
  - refractory counter
  - saturating accumulation
  - a per-timestep valid strobe
- Sits between the synaptic-current source and the spike-event consumer. One instance per neuron.

Parameters:
- WIDTH, 8: membrane state, input current and threshold width (unsigned).
- SHIFT_W, 3: width of leak_shift. Maximum shift is 2^SHIFT_W-1.
- REFRAC_W, 4: width of the refractory counter and of refrac_cycles.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  timestep strobe. The neuron updates only on cycles where in_valid=1.
- current  in  WIDTH  input current for this timestep (unsigned).
- threshold  in  WIDTH  firing threshold. 0 disables firing.
- leak_shift  in  SHIFT_W  leak exponent k. The decayed state is state>>k. k=0 means no leak.
- refrac_cycles  in  REFRAC_W  number of timesteps to hold off after a spike. 0 means no refractory period.
- reset_mode  in  1  selects the post-spike state: 0 = reset to zero, 1 = subtract threshold.
- state  out  WIDTH  membrane potential (registered).
- spike  out  1  one-cycle spike pulse, qualified by out_valid.
- refractory  out  1  high while the refractory counter is non-zero.
- out_valid  out  1  in_valid delayed by one cycle.

Behaviour:
- Reset (reset=1 at a clk edge): state=0, spike=0, refractory=0, out_valid=0, internal counter=0.
  - Reset takes priority over in_valid.
  - Reset in mid-refractory or mid-integration clears everything on the next edge.
- Latency: 1 cycle. Results of a timestep sampled at edge N appear on the outputs after edge N. out_valid is high in that same cycle.
- Config inputs (threshold, leak_shift, refrac_cycles, reset_mode) are sampled on every in_valid cycle. No shadow registers are used.
- in_valid=0:
  - state, counter and refractory hold.
  - spike<=0, out_valid<=0.
- in_valid=1, counter!=0 (refractory timestep):
  - current is ignored.
  - state <= state>>leak_shift.
  - counter decrements by 1.
  - spike<=0.
- in_valid=1, counter==0 (active timestep):
  - sum = (state>>leak_shift) + current, computed at WIDTH+1 bits.
  - sat = min(sum, 2^WIDTH-1).
  - fire = (threshold!=0) && (sat >= threshold).
  - If fire=0: state<=sat, spike<=0.
  - If fire=1:
    - spike<=1.
    - state <= 0 when reset_mode=0, else state <= sat-threshold (never negative, since sat>=threshold).
    - counter <= refrac_cycles.
- refractory output = registered (counter!=0), updated in the same edge as the counter.
- With refrac_cycles=R, the R timesteps after a spike are refractory. The next possible spike is at timestep R+1 after the spike.
- Spikes on consecutive timesteps are allowed when refrac_cycles=0. spike stays high across both cycles only if in_valid is high on both.
- Back-to-back in_valid is supported at full rate. No backpressure.
- leak_shift >= WIDTH yields a decayed state of 0.

Test Plan:
- Leak-only integration.
  - Stimulus: WIDTH=8, leak_shift=1, threshold=0, current=10 on 6 consecutive steps.
  - Response: state 10,15,17,18,19,19; spike never asserts; out_valid high each following cycle.
- Reset-to-zero firing.
  - Stimulus: leak_shift=1, threshold=40, reset_mode=0, refrac=0, current=30.
  - Response: state 30, then spike with state 0, then state 30, then spike, repeating with period 2.
- Subtract mode.
  - Stimulus: as above with reset_mode=1.
  - Response: state 30, spike/5, 32, spike/6, ... Spike on steps 2 and 4.
- Refractory period.
  - Stimulus: threshold=40, refrac_cycles=2, reset_mode=0, current=50 every step.
  - Response: spikes on steps 1, 4 and 7. refractory is high after steps 1 and 2 and low after step 3. State is 0 during refractory.
- Saturation.
  - Stimulus: leak_shift=0, threshold=0, current=200.
  - Response: state 200, 255, 255; no spike.
  - Then threshold=255 on the next step: spike, state 0.
- Gaps and reset.
  - Stimulus 1: insert in_valid=0 cycles between steps.
  - Response 1: state, counter and refractory hold; spike and out_valid are 0.
  - Stimulus 2: assert reset during refractory (counter=2).
  - Response 2: next cycle all outputs are 0. The next active step integrates immediately (no residual refractory).
